// File: rtl/serial_ripple_borrow_subtractor.sv
// serial_ripple_borrow_subtractor: bit-serial d = a - b, LSB first, ripple-borrow flop.
// Start/busy/done handshake; the result and borrow update only at completion.
// Optional macro SUB_OVERFLOW_EN adds a registered two's-complement overflow output ovf.
module serial_ripple_borrow_subtractor #(
  parameter int unsigned nbit = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [nbit-1:0] a,
  input  logic [nbit-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [nbit-1:0] d,
`ifdef SUB_OVERFLOW_EN
  output logic            ovf,
`endif
  output logic            bout
);

  localparam int unsigned W  = nbit;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [W-1:0]    res_q, res_d;
  logic            br_q, br_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    d_q, d_d;
  logic            bout_q, bout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Current-bit datapath signals
  logic            ai, bi, di, br_n;
  logic [W-1:0]    res_nx;

`ifdef SUB_OVERFLOW_EN
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic            ovf_q, ovf_d;
`endif

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SUB_OVERFLOW_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state, one-bit borrow step and output register updates
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SUB_OVERFLOW_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    ai     = a_sh_q[0];
    bi     = b_sh_q[0];
    di     = ai ^ bi ^ br_q;
    br_n   = (~ai & bi) | (~(ai ^ bi) & br_q);
    // New bit enters at the MSB so the word is right-aligned after W shifts
    res_nx = (res_q >> 1) | (W'(di) << (W - 1));

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = BUSY;
`ifdef SUB_OVERFLOW_EN
          a_msb_d = a[W-1];
          b_msb_d = b[W-1];
`endif
        end
      end
      BUSY: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = res_nx;
        br_d   = br_n;
        if (cnt_q == CW'(W - 1)) begin
          d_d     = res_nx;
          bout_d  = br_n;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef SUB_OVERFLOW_EN
          ovf_d   = (a_msb_q != b_msb_q) && (res_nx[W-1] != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule
